// File: rtl/fp_addsub_param.sv
// fp_addsub_param: six-state multi-cycle FP adder/subtractor with RNE rounding and flush-to-zero.
// Define FP_ADDSUB_FLAGS_EN to add the flags[3:0] = {invalid, overflow, underflow, inexact} output.
module fp_addsub_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 op,
    input  logic [EXP_W+MAN_W:0] Number1,
    input  logic [EXP_W+MAN_W:0] Number2,
    input  logic                 result_ack,
    output logic [EXP_W+MAN_W:0] Result,
    output logic                 result_ready,
    output logic                 busy
`ifdef FP_ADDSUB_FLAGS_EN
    ,
    output logic [3:0]           flags
`endif
);

    // state   | meaning
    // IDLE    | waiting for load, operands captured on load
    // ALIGN   | unpack, specials, swap, align smaller operand
    // ADD     | magnitude add or subtract
    // NORM    | normalise, leading-zero shift
    // ROUND   | round-to-nearest-even, range check, register Result
    // DONE    | result_ready high until result_ack

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int MW   = MAN_W + 4;
    localparam int EW   = EXP_W + 2;
    localparam int LZ_W = $clog2(MW + 1);

    localparam logic [EXP_W-1:0]    EXP_ONES  = '1;
    localparam logic [EXP_W-1:0]    SHIFT_MAX = EXP_W'(MAN_W + 3);
    localparam logic [LZ_W-1:0]     LZ_ONE    = 1;
    localparam logic signed [EW-1:0] E_ONE    = 1;
    localparam logic signed [EW-1:0] E_ZERO   = '0;
    localparam logic signed [EW-1:0] E_MAX    = {2'b00, EXP_ONES};
    localparam logic [W-1:0]        QNAN      = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;
    state_t state, state_nxt;

    logic [W-1:0]            a_q, b_q;
    logic                    sgn_q, sub_q, zsign_q, spec_hit_q, zero_q;
    logic [W-1:0]            spec_word_q;
    logic [EXP_W-1:0]        exp_q;
    logic [MW-1:0]           ml_q, ms_q, mn_q;
    logic [MW:0]             sum_q;
    logic signed [EW-1:0]    en_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (load) state_nxt = S_ALIGN;
            S_ALIGN: state_nxt = S_ADD;
            S_ADD:   state_nxt = S_NORM;
            S_NORM:  state_nxt = S_ROUND;
            S_ROUND: state_nxt = S_DONE;
            S_DONE:  if (result_ack) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy         = (state != S_IDLE);
    assign result_ready = (state == S_DONE);

    // ALIGN: unpack, special values, magnitude order, alignment shift
    logic [EXP_W-1:0] ea, eb, el, es, d;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, inv_in, swap, lost;
    logic             spec_hit;
    logic [W-1:0]     spec_word;
    logic [MW-1:0]    ma, mb, ml, ms, ms_tmp, ms_sh;
    logic             sl, ss;

    always_comb begin
        ea     = a_q[W-2:MAN_W];
        eb     = b_q[W-2:MAN_W];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        fa     = a_zero ? '0 : a_q[MAN_W-1:0];
        fb     = b_zero ? '0 : b_q[MAN_W-1:0];
        a_nan  = (ea == EXP_ONES) && (a_q[MAN_W-1:0] != '0);
        b_nan  = (eb == EXP_ONES) && (b_q[MAN_W-1:0] != '0);
        a_inf  = (ea == EXP_ONES) && (a_q[MAN_W-1:0] == '0);
        b_inf  = (eb == EXP_ONES) && (b_q[MAN_W-1:0] == '0);
        inv_in = a_nan | b_nan | (a_inf & b_inf & (a_q[W-1] != b_q[W-1]));
        spec_hit  = inv_in | a_inf | b_inf;
        spec_word = inv_in ? QNAN : (a_inf ? a_q : b_q);

        ma   = a_zero ? '0 : {1'b1, fa, 3'b000};
        mb   = b_zero ? '0 : {1'b1, fb, 3'b000};
        swap = ({eb, fb} > {ea, fa});
        el   = swap ? eb : ea;
        es   = swap ? ea : eb;
        ml   = swap ? mb : ma;
        ms   = swap ? ma : mb;
        sl   = swap ? b_q[W-1] : a_q[W-1];
        ss   = swap ? a_q[W-1] : b_q[W-1];
        d    = el - es;

        ms_tmp = ms >> d;
        lost   = ((ms_tmp << d) != ms);
        if (d >= SHIFT_MAX) ms_sh = {{(MW-1){1'b0}}, |ms};
        else                ms_sh = ms_tmp | {{(MW-1){1'b0}}, lost};
    end

    // NORM: carry-out shifts right with sticky, otherwise shift out leading zeros
    logic [LZ_W-1:0]      lz;
    logic                 found;
    logic [MW-1:0]        m_norm;
    logic signed [EW-1:0] exp_ext, lz_ext, e_norm;

    always_comb begin
        lz    = '0;
        found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!found) begin
                if (sum_q[i]) found = 1'b1;
                else          lz = lz + LZ_ONE;
            end
        end
        exp_ext = {2'b00, exp_q};
        lz_ext  = EW'(lz);
        if (sum_q[MW]) begin
            m_norm = {sum_q[MW:2], sum_q[1] | sum_q[0]};
            e_norm = exp_ext + E_ONE;
        end else begin
            m_norm = sum_q[MW-1:0] << lz;
            e_norm = exp_ext - lz_ext;
        end
    end

    // ROUND: RNE on guard/round/sticky, then overflow to inf or flush to zero
    logic                 rnd_up, ovf, unf;
    logic [MAN_W+1:0]     mr;
    logic [MAN_W-1:0]     frac;
    logic signed [EW-1:0] e_rnd;
    logic [W-1:0]         res_word;

    always_comb begin
        rnd_up = mn_q[2] & (mn_q[1] | mn_q[0] | mn_q[3]);
        mr     = {1'b0, mn_q[MW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
        frac   = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
        e_rnd  = mr[MAN_W+1] ? en_q + E_ONE : en_q;
        ovf    = (e_rnd >= E_MAX);
        unf    = (e_rnd <= E_ZERO);
        if (spec_hit_q)  res_word = spec_word_q;
        else if (zero_q) res_word = {zsign_q, {(W-1){1'b0}}};
        else if (ovf)    res_word = {sgn_q, EXP_ONES, {MAN_W{1'b0}}};
        else if (unf)    res_word = {sgn_q, {(W-1){1'b0}}};
        else             res_word = {sgn_q, e_rnd[EXP_W-1:0], frac};
    end

`ifdef FP_ADDSUB_FLAGS_EN
    logic       spec_inv_q;
    logic [3:0] flags_nxt;
    always_comb begin
        flags_nxt    = '0;
        flags_nxt[3] = spec_hit_q & spec_inv_q;
        if (!spec_hit_q && !zero_q) begin
            flags_nxt[2] = ovf;
            flags_nxt[1] = ~ovf & unf;
            flags_nxt[0] = mn_q[2] | mn_q[1] | mn_q[0] | ovf | unf;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q         <= '0;
            b_q         <= '0;
            sgn_q       <= 1'b0;
            sub_q       <= 1'b0;
            zsign_q     <= 1'b0;
            spec_hit_q  <= 1'b0;
            spec_word_q <= '0;
            exp_q       <= '0;
            ml_q        <= '0;
            ms_q        <= '0;
            sum_q       <= '0;
            mn_q        <= '0;
            en_q        <= '0;
            zero_q      <= 1'b0;
            Result      <= '0;
`ifdef FP_ADDSUB_FLAGS_EN
            spec_inv_q  <= 1'b0;
            flags       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (load) begin
                    a_q <= Number1;
                    b_q <= {Number2[W-1] ^ op, Number2[W-2:0]};
                end
                S_ALIGN: begin
                    sgn_q       <= sl;
                    sub_q       <= sl ^ ss;
                    zsign_q     <= sl & ss;
                    exp_q       <= el;
                    ml_q        <= ml;
                    ms_q        <= ms_sh;
                    spec_hit_q  <= spec_hit;
                    spec_word_q <= spec_word;
`ifdef FP_ADDSUB_FLAGS_EN
                    spec_inv_q  <= inv_in;
`endif
                end
                S_ADD: sum_q <= sub_q ? ({1'b0, ml_q} - {1'b0, ms_q}) : ({1'b0, ml_q} + {1'b0, ms_q});
                S_NORM: begin
                    mn_q   <= m_norm;
                    en_q   <= e_norm;
                    zero_q <= (sum_q == '0);
                end
                S_ROUND: begin
                    Result <= res_word;
`ifdef FP_ADDSUB_FLAGS_EN
                    flags  <= flags_nxt;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_param.sv
// tb_fp_addsub_param: directed vectors against an exact-integer single-precision model.
// Build with FP_ADDSUB_FLAGS_EN defined to also check the flags output.
module tb_fp_addsub_param;

    logic        clk, reset, load, op, result_ack;
    logic [31:0] Number1, Number2, Result;
    logic        result_ready, busy;
`ifdef FP_ADDSUB_FLAGS_EN
    logic [3:0]  flags;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [35:0] exp_q[$];

    fp_addsub_param #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .reset(reset), .load(load), .op(op),
        .Number1(Number1), .Number2(Number2), .result_ack(result_ack),
        .Result(Result), .result_ready(result_ready), .busy(busy)
`ifdef FP_ADDSUB_FLAGS_EN
        , .flags(flags)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Exact sum as a wide integer scaled by 2^149, then rounded to 24 significant bits.
    function automatic logic [35:0] fp_model(input logic [31:0] a, input logic [31:0] bi, input logic sub);
        logic [31:0]  b;
        logic         sa, sb, sr, a_nan, b_nan, a_inf, b_inf, half, rest;
        logic [299:0] ma, mb, mag, keep_w;
        logic [24:0]  keep;
        int           p, e;
        b     = {bi[31] ^ sub, bi[30:0]};
        sa    = a[31];
        sb    = b[31];
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        if (a_nan || b_nan || (a_inf && b_inf && sa != sb)) return {4'b1000, 32'h7FC00000};
        if (a_inf) return {4'b0000, a};
        if (b_inf) return {4'b0000, b};
        ma = (a[30:23] == 0) ? '0 : (300'({1'b1, a[22:0]}) << (int'(a[30:23]) - 1));
        mb = (b[30:23] == 0) ? '0 : (300'({1'b1, b[22:0]}) << (int'(b[30:23]) - 1));
        if (sa == sb)      begin mag = ma + mb; sr = sa; end
        else if (ma >= mb) begin mag = ma - mb; sr = sa; end
        else               begin mag = mb - ma; sr = sb; end
        if (mag == 0) return {4'b0000, sa & sb, 31'b0};
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = p - 22;
        if (p > 23) begin
            keep_w = mag >> (p - 23);
            half   = mag[p - 24];
            rest   = (mag & ((300'd1 << (p - 24)) - 300'd1)) != 0;
        end else begin
            keep_w = mag << (23 - p);
            half   = 1'b0;
            rest   = 1'b0;
        end
        keep = keep_w[24:0];
        if (half && (rest || keep[0])) keep = keep + 25'd1;
        if (keep[24]) begin keep = keep >> 1; e++; end
        if (e >= 255) return {4'b0101, sr, 8'hFF, 23'b0};
        if (e <= 0)   return {4'b0011, sr, 31'b0};
        return {3'b000, half | rest, sr, 8'(e), keep[22:0]};
    endfunction

    // Every cycle a result is presented, it must match the oldest outstanding model result.
    always @(negedge clk) begin
        if (reset && result_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL cmp_unexpected: got result %h expected none", Result);
            end else begin
                check32("cmp_result", Result, exp_q[0][31:0]);
`ifdef FP_ADDSUB_FLAGS_EN
                check32("cmp_flags", {28'b0, flags}, {28'b0, exp_q[0][35:32]});
`endif
                if (result_ack) void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b, input logic o,
                         input logic [31:0] lit, input logic [3:0] lit_flags, input int hold, input bit noise);
        logic [35:0] m;
        int          n;
        bit          seen;
        m = fp_model(a, b, o);
        check32({"model_", name}, m[31:0], lit);
        check32({"model_flags_", name}, {28'b0, m[35:32]}, {28'b0, lit_flags});
        exp_q.push_back(m);
        Number1 = a; Number2 = b; op = o; load = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                load = 1'b0;
                check32({"busy_", name}, {31'b0, busy}, 32'd1);
            end
            if (noise && n == 2) begin
                load = 1'b1; Number1 = 32'h12345678; Number2 = 32'h40A00000; op = ~o;
            end
            if (noise && n == 3) load = 1'b0;
            if (result_ready) seen = 1'b1;
        end
        check32({"latency_", name}, n, 32'd5);
        if (seen) begin
            check32({"result_", name}, Result, lit);
`ifdef FP_ADDSUB_FLAGS_EN
            check32({"flags_", name}, {28'b0, flags}, {28'b0, lit_flags});
`endif
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check32({"hold_ready_", name}, {31'b0, result_ready}, 32'd1);
                check32({"hold_result_", name}, Result, lit);
            end
            result_ack = 1'b1;
            @(posedge clk); #1;
            result_ack = 1'b0;
            check32({"ack_ready_", name}, {31'b0, result_ready}, 32'd0);
            check32({"ack_busy_", name}, {31'b0, busy}, 32'd0);
            check32({"kept_", name}, Result, lit);
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; op = 1'b0; result_ack = 1'b0;
        Number1 = '0; Number2 = '0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check32("reset_result", Result, 32'h0);
        check32("reset_ready", {31'b0, result_ready}, 32'd0);
        check32("reset_busy", {31'b0, busy}, 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        do_op("add_1_2",      32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 20, 1'b1);
        do_op("sub_3_1",      32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, 0, 1'b0);
        do_op("sub_x_x",      32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 0, 1'b0);
        do_op("rne_tie",      32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 1, 1'b0);
        do_op("rne_up",       32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001, 0, 1'b0);
        do_op("inf_minf",     32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000, 0, 1'b0);
        do_op("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 0, 1'b0);
        do_op("denorm_flush", 32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000, 0, 1'b0);
        do_op("neg_zeros",    32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 0, 1'b0);
        do_op("nan_in",       32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 0, 1'b0);
        do_op("neg_inf",      32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000, 0, 1'b0);
        do_op("inf_sub_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 0, 1'b0);
        do_op("underflow",    32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011, 0, 1'b0);
        do_op("far_sticky",   32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001, 0, 1'b0);
        do_op("cancel_norm",  32'h3F800000, 32'hBF7FFFFF, 1'b0, 32'h33800000, 4'b0000, 0, 1'b0);
        do_op("round_carry",  32'h3F7FFFFF, 32'h33000000, 1'b0, 32'h3F800000, 4'b0001, 0, 1'b0);

        // reset dropped while the operation sits in ADD
        Number1 = 32'h40400000; Number2 = 32'h40400000; op = 1'b0; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check32("midreset_ready", {31'b0, result_ready}, 32'd0);
        check32("midreset_busy", {31'b0, busy}, 32'd0);
        check32("midreset_result", Result, 32'h0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        do_op("after_reset",  32'hC0000000, 32'h3F800000, 1'b1, 32'hC0400000, 4'b0000, 0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check32("final_queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
